// File: rtl/score_disp_pkg.sv
// Shared constants for the score display path: digit geometry and
// active-high 7-segment patterns in {g,f,e,d,c,b,a} order.
package score_disp_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int BCD_W      = 4;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-high 7-segment decoder.
// Non-BCD codes show a dash; blank overrides everything.
module bcd_to_seg7
  import score_disp_pkg::*;
(
  input  logic [BCD_W-1:0] nibble,
  input  logic             blank,
  output logic [6:0]       seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_OFF;
    end else begin
      case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/score_seg_scan.sv
// Scans an 8-digit packed-BCD score onto a multiplexed common-anode display,
// taking a tear-free snapshot of the score at the start of every frame.
module score_seg_scan
  import score_disp_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                        clk,
  input  logic                        clr_n,
  input  logic [NUM_DIGITS*BCD_W-1:0] score_bcd,
  input  logic                        blank_lz,
  output logic [6:0]                  seg,
  output logic                        dp,
  output logic [NUM_DIGITS-1:0]       an,
  output logic                        frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [6:0]            SEG_INACT = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_INACT  = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [PW-1:0]               presc_reg;
  logic [2:0]                  idx_reg, idx_next;
  logic [NUM_DIGITS*BCD_W-1:0] snap_reg, snap_next;
  logic [NUM_DIGITS-1:0]       lz_reg, lz_next, lz_calc;
  logic [6:0]                  seg_reg, seg_hi;
  logic [NUM_DIGITS-1:0]       an_reg;
  logic                        fd_reg;
  logic                        tick, wrap;
  logic [BCD_W-1:0]            nib;

  assign tick     = (presc_reg == PW'(SCAN_DIV - 1));
  assign wrap     = tick && (idx_reg == 3'd7);
  assign idx_next = (idx_reg == 3'd7) ? 3'd0 : 3'(idx_reg + 3'd1);

  // A digit blanks only if it and every more significant nibble are zero.
  assign lz_calc[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
      assign lz_calc[gi] = blank_lz &&
                           (score_bcd[NUM_DIGITS*BCD_W-1:BCD_W*gi] == '0);
    end
  endgenerate

  // The digit shown after a frame-start tick must come from the new snapshot.
  always_comb begin
    snap_next = snap_reg;
    lz_next   = lz_reg;
    if (wrap) begin
      snap_next = score_bcd;
      lz_next   = lz_calc;
    end
  end

  assign nib = snap_next[{idx_next, 2'b00} +: BCD_W];

  bcd_to_seg7 u_dec (
    .nibble (nib),
    .blank  (lz_next[idx_next]),
    .seg    (seg_hi)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      presc_reg <= '0;
      idx_reg   <= 3'd7;
      snap_reg  <= '0;
      lz_reg    <= '0;
      seg_reg   <= SEG_INACT;
      an_reg    <= AN_INACT;
      fd_reg    <= 1'b0;
    end else begin
      presc_reg <= tick ? '0 : PW'(presc_reg + 1'b1);
      fd_reg    <= wrap;
      if (tick) begin
        idx_reg  <= idx_next;
        snap_reg <= snap_next;
        lz_reg   <= lz_next;
        seg_reg  <= seg_hi ^ SEG_INACT;
        an_reg   <= (NUM_DIGITS'(1) << idx_next) ^ AN_INACT;
      end
    end
  end

  assign seg        = seg_reg;
  assign an         = an_reg;
  assign dp         = SEG_ACTIVE_LOW;
  assign frame_done = fd_reg;

endmodule

// File: tb/tb_score_seg_scan.sv
// Directed bench for score_seg_scan (SCAN_DIV=4, low-true outputs) with a
// cycle-count based display model checked every cycle, plus literal pins.
module tb_score_seg_scan;

  localparam int DIV = 4;
  localparam int FRAME = DIV * 8;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic [31:0] score_bcd = 32'h0000_1234;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;
  logic        frame_done;

  int checks = 0;
  int passes = 0;
  bit done = 1'b0;

  score_seg_scan #(.SCAN_DIV(DIV), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .score_bcd  (score_bcd),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Standard active-high digit shapes, a=bit0 .. g=bit6.
  function automatic logic [6:0] shape(input logic [3:0] v);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return (v <= 4'd9) ? tbl[v] : 7'h40;
  endfunction

  // Model: n counts clock edges since reset release. Edge k*DIV ends slot k-1;
  // slot m shows digit m%8; every frame's snapshot is taken at edge n%FRAME==DIV.
  int          n = 0;
  logic [31:0] msnap = '0;
  bit          mblz = 1'b0;

  initial begin
    while (!done) begin
      @(posedge clk);
      if (!clr_n) n = 0;
      else begin
        n++;
        if (n % FRAME == DIV) begin
          msnap = score_bcd;
          mblz  = blank_lz;
        end
      end
      #1;
      begin
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_fd;
        int         d;
        e_an = 8'hFF; e_seg = 7'h7F; e_fd = 1'b0;
        if (n >= DIV) begin
          d     = (n / DIV - 1) % 8;
          e_an  = ~(8'h01 << d);
          e_fd  = (n % FRAME == DIV);
          if (mblz && d != 0 && (msnap >> (4 * d)) == 0) e_seg = 7'h7F;
          else e_seg = ~shape(msnap[4*d +: 4]);
        end
        chk("cycle_outputs", {frame_done, dp, 7'(0), seg, 8'(0), an},
            {e_fd, 1'b1, 7'(0), e_seg, 8'(0), e_an});
      end
    end
  end

  task automatic wait_fd(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!frame_done && cnt < 100);
    if (!frame_done) chk("wait_frame_done_timeout", 32'(cnt), 32'(0));
  endtask

  task automatic wait_an(input logic [7:0] val);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (an !== val && c < 100);
    if (an !== val) chk("wait_an_timeout", {24'h0, an}, {24'h0, val});
  endtask

  initial begin
    int cnt;
    repeat (3) @(negedge clk);
    chk("reset_an", {24'h0, an}, 32'h0000_00FF);
    chk("reset_seg", {25'h0, seg}, 32'h0000_007F);
    clr_n = 1'b1;

    // 1: plain digits, no blanking
    wait_fd(cnt);
    chk("first_fd_latency", 32'(cnt), 32'(DIV));
    chk("t1_d0_an", {24'h0, an}, 32'hFE);
    chk("t1_d0_seg", {25'h0, seg}, 32'h19);
    repeat (DIV) @(negedge clk);
    chk("t1_d1_an", {24'h0, an}, 32'hFD);
    chk("t1_d1_seg", {25'h0, seg}, 32'h30);

    // 2: leading-zero blanking keeps interior zero
    score_bcd = 32'h0000_0105; blank_lz = 1'b1;
    wait_fd(cnt);
    chk("t2_d0_seg", {25'h0, seg}, 32'h12);
    repeat (2 * DIV) @(negedge clk);
    chk("t2_d2_seg", {25'h0, seg}, 32'h79);
    repeat (DIV) @(negedge clk);
    chk("t2_d3_an", {24'h0, an}, 32'hF7);
    chk("t2_d3_seg", {25'h0, seg}, 32'h7F);

    // 3: zero score shows a single 0
    score_bcd = 32'h0; blank_lz = 1'b1;
    wait_fd(cnt);
    chk("t3_d0_seg", {25'h0, seg}, 32'h40);
    repeat (DIV) @(negedge clk);
    chk("t3_d1_seg", {25'h0, seg}, 32'h7F);

    // 4: mid-frame change is held off until the next frame
    score_bcd = 32'h11; blank_lz = 1'b0;
    wait_fd(cnt);
    wait_an(8'hF7);
    score_bcd = 32'h99;
    wait_an(8'hEF);
    chk("t4_d4_seg", {25'h0, seg}, 32'h40);
    wait_fd(cnt);
    chk("t4_new_d0_seg", {25'h0, seg}, 32'h10);

    // 5: non-BCD nibble shows a dash
    score_bcd = 32'h0000_00B7;
    wait_fd(cnt);
    wait_fd(cnt);
    repeat (DIV) @(negedge clk);
    chk("t5_d1_an", {24'h0, an}, 32'hFD);
    chk("t5_d1_seg", {25'h0, seg}, 32'h3F);

    // 6: asynchronous reset mid-frame
    wait_an(8'hDF);
    #2 clr_n = 1'b0;
    #1;
    chk("t6_async_an", {24'h0, an}, 32'hFF);
    chk("t6_async_seg", {25'h0, seg}, 32'h7F);
    chk("t6_async_fd", {31'h0, frame_done}, 32'h0);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    wait_fd(cnt);
    chk("t6_restart_latency", 32'(cnt), 32'(DIV));
    chk("t6_restart_an", {24'h0, an}, 32'hFE);
    chk("t6_restart_seg", {25'h0, seg}, 32'h78);
    repeat (FRAME + 4) @(negedge clk);

    done = 1'b1;
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
